reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, as the register width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 3, as the address width; NUM_REGS = 2**ADDR_W (8).
REQ-003 The module SHALL have port CLK, input, 1, as the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port RESET, input, 1; reset is synchronous and active-high.
REQ-005 The module SHALL have port IN, input, DATA_W, as write data (ALU result).
REQ-006 The module SHALL have port INADDRESS, input, ADDR_W, as the write register index.
REQ-007 The module SHALL have port WRITE, input, 1, as write enable.
REQ-008 The module SHALL have port OUT1ADDRESS, input, ADDR_W, as the read port 1 index.
REQ-009 The module SHALL have port OUT2ADDRESS, input, ADDR_W, as the read port 2 index.
REQ-010 The module SHALL have port OUT1, output, DATA_W, as read port 1 data (ALU data1 operand).
REQ-011 The module SHALL have port OUT2, output, DATA_W, as read port 2 data (ALU data2 operand).
REQ-012 The module SHALL have port VALID, output, NUM_REGS; bit i is set once register i has been written since reset.

Function
REQ-013 Reads SHALL be combinational, 0-cycle latency: OUTn = reg[OUTnADDRESS], with both ports independent, including same-address reads.
REQ-014 At a rising CLK edge with WRITE=1 and RESET=0, reg[INADDRESS] SHALL take IN and VALID[INADDRESS] SHALL be set; no other register or VALID bit SHALL change.
REQ-015 WRITE=0 SHALL leave all registers and VALID unchanged.
REQ-016 All NUM_REGS registers, including index 0, SHALL be writable; there is no hardwired-zero register.
REQ-017 Same-cycle write and read of one address without bypass SHALL give the old value before the edge and the new value after it.
REQ-018 Back-to-back writes to one address on consecutive cycles SHALL each take effect, with the last value winning.
REQ-019 Address arithmetic SHALL be unsigned ADDR_W bits, with no wrap or out-of-range case because the full index space is populated.

Reset
REQ-020 At a rising edge with RESET=1, all registers SHALL be cleared to 0 and VALID to 0; OUT1 and OUT2 SHALL then read 0.
REQ-021 RESET SHALL dominate WRITE, so a write presented in a reset cycle is dropped and its VALID bit stays 0.
REQ-022 Reset asserted between writes SHALL discard all prior contents, and the first post-reset write SHALL behave per REQ-014.
REQ-023 Before the first reset edge, register contents and VALID are undefined; the bench SHALL not check them.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN: when defined, OUTn SHALL equal IN whenever WRITE=1, RESET=0 and OUTnADDRESS==INADDRESS (write-to-read forwarding in the same cycle).
REQ-025 Bypass SHALL be evaluated per port independently, and SHALL be suppressed when RESET=1.
REQ-026 When REGFILE_BYPASS_EN is undefined, REQ-017 SHALL apply, and there SHALL be no bypass logic or paths.

Structure
REQ-027 Package regfile_pkg SHALL hold DATA_W, ADDR_W and NUM_REGS defaults and the register-index type.
REQ-028 Sub-module reg_read_port (array mux plus optional bypass) SHALL be instantiated once per read port.
REQ-029 Storage, write decode and VALID SHALL reside in reg_file.

Verification
REQ-030 Bench SHALL check: RESET=1 for one edge, then read all 8 addresses -> all 0, VALID=8'h00.
REQ-031 Bench SHALL check: write 8'h2A to R3 and 8'hF0 to R5 on successive cycles, OUT1ADDRESS=3, OUT2ADDRESS=5 -> OUT1=8'h2A, OUT2=8'hF0, VALID=8'h28.
REQ-032 Bench SHALL check: R3=8'h2A, then WRITE=1, IN=8'h55, INADDRESS=3, OUT1ADDRESS=3 -> OUT1=8'h2A before the edge (8'h55 with bypass) and 8'h55 after.
REQ-033 Bench SHALL check: RESET=1 with WRITE=1, IN=8'h77, INADDRESS=1 -> R1=0, VALID[1]=0 after the edge.
REQ-034 Bench SHALL check: WRITE=0, IN=8'hFF, INADDRESS=0 for 3 cycles -> R0 unchanged, VALID unchanged.
REQ-035 Bench SHALL check: both read ports on R7 after writing 8'h81 -> OUT1=OUT2=8'h81.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared defaults for the register file slice: data width, address width,
// register count and the register-index type used by the register file and
// its read ports.
// Optional build macro (used by reg_file / reg_read_port): REGFILE_BYPASS_EN
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Register index at the default address width
  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_read_port.sv
// ---------------------------------------------------------------------------
// reg_read_port
// One combinational read port of the register file: selects one register
// from the flattened storage array. When REGFILE_BYPASS_EN is defined, a
// write in flight to the same index is forwarded straight to the output.
//
// Ports
//   regs      in   all registers, packed, index i at regs[i]
//   addr      in   register index to read
//   wr_data   in   write data in flight            (REGFILE_BYPASS_EN only)
//   wr_addr   in   write index in flight           (REGFILE_BYPASS_EN only)
//   fwd_en    in   write in flight and not reset   (REGFILE_BYPASS_EN only)
//   data      out  read data
// ---------------------------------------------------------------------------
module reg_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  addr,
`ifdef REGFILE_BYPASS_EN
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic                               fwd_en,
`endif
  output logic [DATA_W-1:0]                  data
);

`ifdef REGFILE_BYPASS_EN
  // Same-cycle forwarding: a write landing on the index being read wins
  // over the stored value so the reader sees it without waiting an edge.
  always_comb begin
    data = regs[addr];
    if (fwd_en && (wr_addr == addr)) begin
      data = wr_data;
    end
  end
`else
  // Plain array mux: the stored value only changes on the clock edge.
  always_comb begin
    data = regs[addr];
  end
`endif

endmodule

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// 2**ADDR_W x DATA_W register file with one synchronous write port, two
// independent combinational read ports and a per-register "written since
// reset" flag vector. Every index, including 0, is a real register.
//
// Ports
//   CLK          in   clock, all state updates on the rising edge
//   RESET        in   synchronous active-high reset, dominates WRITE
//   IN           in   write data (ALU result)
//   INADDRESS    in   write register index
//   WRITE        in   write enable
//   OUT1ADDRESS  in   read port 1 index
//   OUT2ADDRESS  in   read port 2 index
//   OUT1         out  read port 1 data (ALU data1 operand)
//   OUT2         out  read port 2 data (ALU data2 operand)
//   VALID        out  bit i set once register i written since reset
//
// Build macro: REGFILE_BYPASS_EN -- forwards IN to a read port whose index
// matches INADDRESS while a non-reset write is in flight.
// ---------------------------------------------------------------------------
module reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [DATA_W-1:0]         IN,
  input  logic [ADDR_W-1:0]         INADDRESS,
  input  logic                      WRITE,
  input  logic [ADDR_W-1:0]         OUT1ADDRESS,
  input  logic [ADDR_W-1:0]         OUT2ADDRESS,
  output logic [DATA_W-1:0]         OUT1,
  output logic [DATA_W-1:0]         OUT2,
  output logic [(2**ADDR_W)-1:0]    VALID
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             validBits;

  // Storage and written-flags. Reset clears everything and swallows any
  // write presented in the same cycle; otherwise a write touches exactly
  // one register and its flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs      <= '0;
      validBits <= '0;
    end else if (WRITE) begin
      regs[INADDRESS]      <= IN;
      validBits[INADDRESS] <= 1'b1;
    end
  end

  assign VALID = validBits;

`ifdef REGFILE_BYPASS_EN
  // Forwarding is only legal when the write will actually commit.
  logic fwdEn;
  assign fwdEn = WRITE & ~RESET;
`endif

  // Two identical, independent read ports.
  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) readPort1 (
    .regs    (regs),
    .addr    (OUT1ADDRESS),
`ifdef REGFILE_BYPASS_EN
    .wr_data (IN),
    .wr_addr (INADDRESS),
    .fwd_en  (fwdEn),
`endif
    .data    (OUT1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) readPort2 (
    .regs    (regs),
    .addr    (OUT2ADDRESS),
`ifdef REGFILE_BYPASS_EN
    .wr_data (IN),
    .wr_addr (INADDRESS),
    .fwd_en  (fwdEn),
`endif
    .data    (OUT2)
  );

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file: directed scenarios followed by random
// traffic, all compared against an array model of the register file.
// Honours REGFILE_BYPASS_EN in its expected read values.
// ---------------------------------------------------------------------------
module tb_reg_file;
  import regfile_pkg::*;

  logic           clk;
  logic           reset;
  logic [7:0]     inData;
  reg_idx_t       inAddr;
  logic           write;
  reg_idx_t       rdAddr1;
  reg_idx_t       rdAddr2;
  logic [7:0]     out1;
  logic [7:0]     out2;
  logic [7:0]     valid;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: plain arrays of contents and written flags
  logic [7:0] modelRegs  [8];
  bit         modelValid [8];

  reg_file dut (
    .CLK         (clk),
    .RESET       (reset),
    .IN          (inData),
    .INADDRESS   (inAddr),
    .WRITE       (write),
    .OUT1ADDRESS (rdAddr1),
    .OUT2ADDRESS (rdAddr2),
    .OUT1        (out1),
    .OUT2        (out2),
    .VALID       (valid)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  // Drive all inputs, then let combinational reads settle
  task automatic applyStimulus(input logic rst, input logic wr, input logic [7:0] d,
                               input int wa, input int a1, input int a2);
    reset   = rst;
    write   = wr;
    inData  = d;
    inAddr  = reg_idx_t'(wa);
    rdAddr1 = reg_idx_t'(a1);
    rdAddr2 = reg_idx_t'(a2);
    #1;
  endtask

  // Advance one rising edge and apply the same edge to the model
  task automatic stepClock();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        modelRegs[i]  = 8'h00;
        modelValid[i] = 1'b0;
      end
    end else if (write) begin
      modelRegs[inAddr]  = inData;
      modelValid[inAddr] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [7:0] expectedRead(input reg_idx_t a);
`ifdef REGFILE_BYPASS_EN
    if (write && !reset && (a == inAddr)) return inData;
`endif
    return modelRegs[a];
  endfunction

  function automatic logic [7:0] expectedValid();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = modelValid[i];
    return v;
  endfunction

  // Compare both read ports and the flag vector against the model
  task automatic checkReads(input string tag);
    checkOutput({tag, ".out1"}, 32'(out1), 32'(expectedRead(rdAddr1)));
    checkOutput({tag, ".out2"}, 32'(out2), 32'(expectedRead(rdAddr2)));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(expectedValid()));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      modelRegs[i]  = 8'h00;
      modelValid[i] = 1'b0;
    end

    // Reset for one edge, then every register reads zero
    applyStimulus(1'b1, 1'b0, 8'h00, 0, 0, 0);
    stepClock();
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 0, a, 7 - a);
      checkOutput($sformatf("rst.out1[%0d]", a), 32'(out1), 32'h0);
      checkOutput($sformatf("rst.out2[%0d]", 7 - a), 32'(out2), 32'h0);
    end
    checkOutput("rst.valid", 32'(valid), 32'h00);

    // Two writes on successive cycles, read back on both ports
    applyStimulus(1'b0, 1'b1, 8'h2A, 3, 0, 0);
    stepClock();
    applyStimulus(1'b0, 1'b1, 8'hF0, 5, 0, 0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 8'h00, 0, 3, 5);
    checkOutput("wr2.out1", 32'(out1), 32'h2A);
    checkOutput("wr2.out2", 32'(out2), 32'hF0);
    checkOutput("wr2.valid", 32'(valid), 32'h28);

    // Write and read the same register in one cycle
    applyStimulus(1'b0, 1'b1, 8'h55, 3, 3, 5);
`ifdef REGFILE_BYPASS_EN
    checkOutput("rmw.before", 32'(out1), 32'h55);
`else
    checkOutput("rmw.before", 32'(out1), 32'h2A);
`endif
    checkOutput("rmw.port2", 32'(out2), 32'hF0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 8'h00, 0, 3, 5);
    checkOutput("rmw.after", 32'(out1), 32'h55);

    // Reset dominates a simultaneous write
    applyStimulus(1'b1, 1'b1, 8'h77, 1, 1, 1);
    checkOutput("rstwr.nobypass", 32'(out1), 32'(modelRegs[1]));
    stepClock();
    applyStimulus(1'b0, 1'b0, 8'h00, 0, 1, 3);
    checkOutput("rstwr.r1", 32'(out1), 32'h00);
    checkOutput("rstwr.r3", 32'(out2), 32'h00);
    checkOutput("rstwr.valid1", 32'(valid[1]), 32'h0);
    checkOutput("rstwr.valid", 32'(valid), 32'h00);

    // First write after reset, then three idle cycles with junk on IN
    applyStimulus(1'b0, 1'b1, 8'h3C, 0, 0, 0);
    stepClock();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 8'hFF, 0, 0, 0);
      stepClock();
      checkOutput($sformatf("idle%0d.r0", c), 32'(out1), 32'h3C);
      checkOutput($sformatf("idle%0d.valid", c), 32'(valid), 32'h01);
    end

    // Both ports on R7
    applyStimulus(1'b0, 1'b1, 8'h81, 7, 0, 0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 8'h00, 0, 7, 7);
    checkOutput("dual.out1", 32'(out1), 32'h81);
    checkOutput("dual.out2", 32'(out2), 32'h81);

    // Back-to-back writes to one register, last value wins
    applyStimulus(1'b0, 1'b1, 8'hA1, 6, 6, 6);
    stepClock();
    applyStimulus(1'b0, 1'b1, 8'hB2, 6, 6, 0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 8'h00, 0, 6, 7);
    checkOutput("b2b.r6", 32'(out1), 32'hB2);
    checkReads("b2b");

    // Random traffic: reads checked before and after every edge
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
                    8'($urandom), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      checkReads($sformatf("rnd%0d.pre", n));
      stepClock();
      checkReads($sformatf("rnd%0d.post", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
